// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per req/ack handshake,
// and holds the latched instruction for decode until it is accepted or redirected.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [15:0] imm16,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  logic [31:0] redir_pc;
  logic [31:0] pc_inc;

  assign redir_pc = redirect_pc & ~32'd3;
  assign pc_inc   = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_RESET;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      instr_q      <= '0;
      pc_out_q     <= '0;
      pc_plus4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    pc_plus4_d   = pc_plus4_q;
    imem_req     = 1'b0;
    imem_addr    = pc_q;
    instr_valid  = 1'b0;

    unique case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (redirect) begin
            pc_d = redir_pc;
          end else begin
            instr_d    = imem_rdata;
            pc_out_d   = pc_q;
            pc_plus4_d = pc_inc;
            pc_d       = pc_inc;
            state_d    = S_HOLD;
          end
        end else if (redirect) begin
          // Outstanding handshake must complete, so remember its address.
          drain_addr_d = pc_q;
          pc_d         = redir_pc;
          state_d      = S_DRAIN;
        end
      end

      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (redirect) begin
          pc_d = redir_pc;
        end
        if (imem_ack) begin
          state_d = S_FETCH;
        end
      end

      S_HOLD: begin
        instr_valid = 1'b1;
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = S_FETCH;
        end else if (instr_ready) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  assign instr    = instr_q;
  assign imm16    = instr_q[15:0];
  assign pc_out   = pc_out_q;
  assign pc_plus4 = pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized traffic, all checked
// each cycle against a transaction-level model of the fetch flow.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .imm16      (imm16),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Model: a request is outstanding (m_out) to m_req_addr, possibly already
  // made obsolete (m_stale); m_pc is where the next request goes.
  logic        m_gap = 1'b1;
  logic        m_out = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_have = 1'b0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_req_addr = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pcout = '0;
  logic [31:0] m_plus4 = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_7FFF;
    if (a == 32'h0040_0004) return 32'h2009_8000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic issue();
    m_out      = 1'b1;
    m_req_addr = m_pc;
    m_stale    = 1'b0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_gap = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_have = 1'b0;
      m_pc = RESET_PC; m_instr = '0; m_pcout = '0; m_plus4 = '0;
    end else if (m_gap) begin
      m_gap = 1'b0;
      issue();
    end else if (m_out) begin
      if (redirect) m_pc = redirect_pc & ~32'd3;
      if (imem_ack) begin
        if (!m_stale && !redirect) begin
          m_instr = mem_word(m_req_addr);
          m_pcout = m_req_addr;
          m_plus4 = m_req_addr + 32'd4;
          m_pc    = m_plus4;
          m_have  = 1'b1;
          m_out   = 1'b0;
        end else begin
          issue();
        end
      end else if (redirect) begin
        m_stale = 1'b1;
      end
    end else if (m_have) begin
      if (redirect) begin
        m_pc   = redirect_pc & ~32'd3;
        m_have = 1'b0;
        issue();
      end else if (instr_ready) begin
        m_have = 1'b0;
        issue();
      end
    end
  endtask

  task automatic check_outputs();
    chk("req",      32'(imem_req), 32'(m_out));
    chk("addr",     imem_addr, m_out ? m_req_addr : m_pc);
    chk("valid",    32'(instr_valid), 32'(m_have));
    chk("instr",    instr, m_instr);
    chk("imm16",    32'(imm16), 32'(m_instr[15:0]));
    chk("pc_out",   pc_out, m_pcout);
    chk("pc_plus4", pc_plus4, m_plus4);
  endtask

  task automatic tick(input logic r, input logic a, input logic rd,
                      input logic [31:0] rpc, input logic rdy);
    rst_n       = r;
    imem_ack    = a;
    imem_rdata  = a ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    redirect    = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    // Reset, then zero-wait fetch of two words.
    tick(0, 0, 0, '0, 0);
    tick(0, 0, 0, '0, 0);
    tick(1, 0, 0, '0, 1);
    chk("t1_addr0", imem_addr, 32'h0040_0000);
    tick(1, 1, 0, '0, 1);
    chk("t1_pc0",   pc_out,         32'h0040_0000);
    chk("t1_imm0",  32'(imm16),     32'h0000_7FFF);
    chk("t1_p4_0",  pc_plus4,       32'h0040_0004);
    tick(1, 0, 0, '0, 1);
    tick(1, 1, 0, '0, 1);
    chk("t1_pc1",   pc_out,         32'h0040_0004);
    chk("t1_imm1",  32'(imm16),     32'h0000_8000);
    tick(1, 0, 0, '0, 1);

    // Delayed ack, then decode stalls.
    tick(1, 0, 0, '0, 0);
    tick(1, 0, 0, '0, 0);
    tick(1, 0, 0, '0, 0);
    tick(1, 1, 0, '0, 0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, '0, 0);
    chk("t2_noreq", 32'(imem_req), 32'd0);
    tick(1, 0, 0, '0, 1);

    // Redirect in FETCH with the ack arriving later.
    tick(1, 0, 1, 32'h0040_0103, 0);
    tick(1, 0, 0, '0, 0);
    tick(1, 1, 0, '0, 0);
    chk("t3_addr",  imem_addr,        32'h0040_0100);
    chk("t3_valid", 32'(instr_valid), 32'd0);
    tick(1, 1, 0, '0, 0);
    chk("t3_pc",    pc_out,           32'h0040_0100);

    // Redirect in HOLD together with instr_ready.
    tick(1, 0, 1, 32'h0040_0200, 1);
    chk("t4_addr",  imem_addr,        32'h0040_0200);
    chk("t4_valid", 32'(instr_valid), 32'd0);

    // Redirect to the top of memory, accept, wrap to zero.
    tick(1, 1, 1, 32'hFFFF_FFFC, 0);
    tick(1, 1, 0, '0, 1);
    chk("t5_p4",    pc_plus4,  32'h0000_0000);
    tick(1, 0, 0, '0, 1);
    chk("t5_addr",  imem_addr, 32'h0000_0000);

    // Reset while draining, stray ack afterwards.
    tick(1, 0, 1, 32'h0040_0300, 0);
    tick(0, 0, 0, '0, 0);
    tick(1, 1, 0, '0, 0);
    chk("t6_addr",  imem_addr,   32'h0040_0000);
    tick(1, 1, 0, '0, 1);
    chk("t6_pc",    pc_out,      32'h0040_0000);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r, a, rd, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 149) != 0);
      rd  = !m_gap && ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom);
      a   = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      tick(r, a, rd, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the MIPS core. It holds the PC, fetches one instruction word from instruction memory over a req/ack handshake, and presents the instruction plus its extracted imm16 field to decode. The imm16 output feeds the sign extender directly. It accepts PC redirects for branches and jumps from downstream and discards any fetch made obsolete by a redirect.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset (word aligned)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  32  fetch address, stable while imem_req=1
imem_ack  input  1  single-cycle acknowledge; imem_rdata valid in same cycle
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  instr/pc_out/pc_plus4/imm16 valid for decode
instr_ready  input  1  decode accepts the current instruction
instr  output  32  latched instruction word
imm16  output  16  instr[15:0], to sign extender
pc_out  output  32  address of the latched instruction
pc_plus4  output  32  pc_out + 4
redirect  input  1  single-cycle pulse: discard current flow, fetch from redirect_pc
redirect_pc  input  32  new PC; bits [1:0] ignored (forced 0)

Behaviour:
- Reset is synchronous: rst_n=0 sampled at a clk edge sets state=RESET, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, imm16=0, pc_out=0, pc_plus4=0. Reset overrides every other input, including mid-fetch; an in-flight ack arriving after reset is ignored.
- States: RESET, FETCH, HOLD, DRAIN. imem_addr=pc in every state except DRAIN, where it holds the abandoned address.
- RESET: imem_req=0. Moves to FETCH on the first edge with rst_n=1.
- FETCH: imem_req=1. Transitions:
  - ack=1, redirect=0: latch instr=imem_rdata, pc_out=pc, pc_plus4=pc+4; set pc=pc+4 and instr_valid=1; go to HOLD.
  - ack=1, redirect=1: drop the data; pc=redirect_pc&~3; stay in FETCH.
  - ack=0, redirect=1: pc=redirect_pc&~3; go to DRAIN. The handshake is never abandoned.
  - ack=0, redirect=0: stay in FETCH; address stays stable.
- DRAIN: imem_req=1 with the old address.
  - On ack: data dropped, instr_valid stays 0, go to FETCH with the new pc.
  - A further redirect in DRAIN overwrites pc (last redirect wins).
  - Redirect and ack in the same cycle: the new pc is taken, then go to FETCH.
- HOLD: imem_req=0; instr_valid=1 and all outputs held stable.
  - instr_ready=1: instr_valid=0, go to FETCH next cycle.
  - redirect=1, with or without instr_ready: instr_valid=0, pc=redirect_pc&~3, go to FETCH. The held instruction counts as discarded, not consumed.
- Latency: ack edge to instr_valid=1 is 1 cycle. Zero-wait memory gives a peak rate of 1 instruction per 2 cycles.
- imem_req rises the cycle after an instruction is accepted or redirected.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- imm16 is always instr[15:0], registered with instr. No extension happens here; sign extension is the downstream block's job.
- No imem_ack outside FETCH or DRAIN is expected. If one arrives, it is ignored.

Test Plan:
1. Reset then zero-wait memory returning 32'h2008_7FFF at 0x00400000 and 32'h2009_8000 at 0x00400004, instr_ready=1 → two valid beats. Beat 1: pc_out=0x00400000, imm16=0x7FFF, pc_plus4=0x00400004. Beat 2: pc_out=0x00400004, imm16=0x8000.
2. imem_ack delayed 3 cycles → imem_req/imem_addr stable for all 4 cycles. Then instr_valid=1 for one instruction. With instr_ready=0 for 5 cycles, all outputs are held, imem_req=0, and there is no second request.
3. Redirect to 0x00400103 while in FETCH, ack 2 cycles later → old data dropped (instr_valid stays 0). Next request is to 0x00400100, which returns an instruction with pc_out=0x00400100.
4. Redirect in HOLD with instr_ready=1 in the same cycle → instr_valid falls and the next imem_addr is redirect_pc. The held instruction is never re-presented.
5. Redirect to 0xFFFFFFFC, then accept → next fetch address 0x00000000, pc_plus4=0x00000000.
6. rst_n=0 for one cycle during DRAIN, with ack the cycle after → outputs return to reset values, the ack is ignored, and the next fetch address is 0x00400000.
